// File: rtl/exu_lsu_ctrl.sv
// LSU control: AGU command -> one DTCM access -> aligned write-back, 1-cycle load latency, one command/cycle;
// response held stable (load data parked in hold_q) while either reader stalls. LSU_MISALGN_CHK_EN enables misalign errors.
module exu_lsu_ctrl #(
   parameter int XLEN            = 32,
   parameter int DTCM_ADDR_WIDTH = 16,
   parameter int ITAG_WIDTH      = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       agu_cmd_valid,
   output logic                       agu_cmd_ready,
   input  logic [DTCM_ADDR_WIDTH-1:0] agu_cmd_addr,
   input  logic                       agu_cmd_read,
   input  logic [XLEN-1:0]            agu_cmd_wdata,
   input  logic [XLEN/8-1:0]          agu_cmd_wmask,
   input  logic [ITAG_WIDTH-1:0]      agu_cmd_itag,
   input  logic                       agu_cmd_usign,
   input  logic [1:0]                 agu_cmd_size,
   output logic                       agu_rsp_valid,
   input  logic                       agu_rsp_ready,
   output logic                       dtcm_cs,
   output logic                       dtcm_we,
   output logic [DTCM_ADDR_WIDTH-3:0] dtcm_addr,
   output logic [XLEN/8-1:0]          dtcm_wem,
   output logic [XLEN-1:0]            dtcm_din,
   input  logic [XLEN-1:0]            dtcm_dout,
   output logic                       lsu_o_valid,
   input  logic                       lsu_o_ready,
   output logic [XLEN-1:0]            lsu_o_wbck_wdat,
   output logic [ITAG_WIDTH-1:0]      lsu_o_wbck_itag,
   output logic                       lsu_o_wbck_read,
   output logic                       lsu_o_err
);

   logic                  cmd_hsk, rsp_hsk, err_c, acc_c;
   logic                  pend_vld_q, pend_vld_d;
   logic                  hold_vld_q, hold_vld_d;
   logic [XLEN-1:0]       hold_q, hold_d;
   logic [1:0]            addr_lo_q, addr_lo_d;
   logic                  read_q, read_d;
   logic                  usign_q, usign_d;
   logic [1:0]            size_q, size_d;
   logic [ITAG_WIDTH-1:0] itag_q, itag_d;
   logic                  err_q, err_d;
   logic [XLEN-1:0]       sel_data, raw, ext;

`ifdef LSU_MISALGN_CHK_EN
   assign err_c = ((agu_cmd_size == 2'b01) & agu_cmd_addr[0]) |
                  ((agu_cmd_size == 2'b10) & (agu_cmd_addr[1:0] != 2'b00));
`else
   assign err_c = 1'b0;
`endif

   assign rsp_hsk       = pend_vld_q & lsu_o_ready & agu_rsp_ready;
   assign agu_cmd_ready = ~pend_vld_q | rsp_hsk;
   assign cmd_hsk       = agu_cmd_valid & agu_cmd_ready;
   assign acc_c         = cmd_hsk & ~err_c;

   assign dtcm_cs   = acc_c;
   assign dtcm_we   = acc_c & ~agu_cmd_read;
   assign dtcm_addr = acc_c ? agu_cmd_addr[DTCM_ADDR_WIDTH-1:2] : '0;
   assign dtcm_wem  = (acc_c & ~agu_cmd_read) ? agu_cmd_wmask : '0;
   assign dtcm_din  = acc_c ? agu_cmd_wdata : '0;

   always_comb begin
      pend_vld_d = pend_vld_q;
      hold_vld_d = hold_vld_q;
      hold_d     = hold_q;
      addr_lo_d  = addr_lo_q;
      read_d     = read_q;
      usign_d    = usign_q;
      size_d     = size_q;
      itag_d     = itag_q;
      err_d      = err_q;
      if (cmd_hsk) begin
         pend_vld_d = 1'b1;
         addr_lo_d  = agu_cmd_addr[1:0];
         read_d     = agu_cmd_read;
         usign_d    = agu_cmd_usign;
         size_d     = agu_cmd_size;
         itag_d     = agu_cmd_itag;
         err_d      = err_c;
      end else if (rsp_hsk) begin
         pend_vld_d = 1'b0;
      end
      // SRAM output is only valid for one cycle; park it if the response stalls.
      if (rsp_hsk) begin
         hold_vld_d = 1'b0;
      end else if (pend_vld_q & ~hold_vld_q & read_q & ~err_q) begin
         hold_vld_d = 1'b1;
         hold_d     = dtcm_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld_q <= 1'b0;
         hold_vld_q <= 1'b0;
         hold_q     <= '0;
         addr_lo_q  <= '0;
         read_q     <= 1'b0;
         usign_q    <= 1'b0;
         size_q     <= '0;
         itag_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         pend_vld_q <= pend_vld_d;
         hold_vld_q <= hold_vld_d;
         hold_q     <= hold_d;
         addr_lo_q  <= addr_lo_d;
         read_q     <= read_d;
         usign_q    <= usign_d;
         size_q     <= size_d;
         itag_q     <= itag_d;
         err_q      <= err_d;
      end
   end

   assign sel_data = hold_vld_q ? hold_q : dtcm_dout;
   assign raw      = sel_data >> {addr_lo_q, 3'b000};

   always_comb begin
      ext = raw;
      case (size_q)
         2'b00:   ext = usign_q ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         2'b01:   ext = usign_q ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default: ext = raw;
      endcase
   end

   assign lsu_o_valid     = pend_vld_q;
   assign agu_rsp_valid   = pend_vld_q;
   assign lsu_o_wbck_wdat = (pend_vld_q & read_q & ~err_q) ? ext : '0;
   assign lsu_o_wbck_itag = pend_vld_q ? itag_q : '0;
   assign lsu_o_wbck_read = pend_vld_q & read_q;
   assign lsu_o_err       = pend_vld_q & err_q;

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// Bench for exu_lsu_ctrl: directed test-plan cases with literal expectations, then randomized
// traffic checked every cycle against a queue/array model of commands, memory and responses.
module tb_exu_lsu_ctrl;

   logic        clk, rst;
   logic        agu_cmd_valid, agu_cmd_ready;
   logic [15:0] agu_cmd_addr;
   logic        agu_cmd_read;
   logic [31:0] agu_cmd_wdata;
   logic [3:0]  agu_cmd_wmask;
   logic [0:0]  agu_cmd_itag;
   logic        agu_cmd_usign;
   logic [1:0]  agu_cmd_size;
   logic        agu_rsp_valid, agu_rsp_ready;
   logic        dtcm_cs, dtcm_we;
   logic [13:0] dtcm_addr;
   logic [3:0]  dtcm_wem;
   logic [31:0] dtcm_din, dtcm_dout;
   logic        lsu_o_valid, lsu_o_ready;
   logic [31:0] lsu_o_wbck_wdat;
   logic [0:0]  lsu_o_wbck_itag;
   logic        lsu_o_wbck_read, lsu_o_err;

   exu_lsu_ctrl dut (
      .clk(clk), .rst(rst),
      .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready),
      .agu_cmd_addr(agu_cmd_addr), .agu_cmd_read(agu_cmd_read),
      .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
      .agu_cmd_itag(agu_cmd_itag), .agu_cmd_usign(agu_cmd_usign),
      .agu_cmd_size(agu_cmd_size),
      .agu_rsp_valid(agu_rsp_valid), .agu_rsp_ready(agu_rsp_ready),
      .dtcm_cs(dtcm_cs), .dtcm_we(dtcm_we), .dtcm_addr(dtcm_addr),
      .dtcm_wem(dtcm_wem), .dtcm_din(dtcm_din), .dtcm_dout(dtcm_dout),
      .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready),
      .lsu_o_wbck_wdat(lsu_o_wbck_wdat), .lsu_o_wbck_itag(lsu_o_wbck_itag),
      .lsu_o_wbck_read(lsu_o_wbck_read), .lsu_o_err(lsu_o_err)
   );

   typedef struct {
      logic [31:0] wdat;
      logic        itag;
      logic        read;
      logic        err;
   } rsp_t;

   int          checks = 0;
   int          errors = 0;
   rsp_t        exp_q[$];
   logic [31:0] sram_mem [16];
   logic [31:0] ref_mem  [16];
   logic        rd_pend = 1'b0;
   logic [31:0] rd_data = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic us);
      int unsigned r, v;
      r = w >> (8 * off);
      if (sz == 2'd0) begin
         v = r % 256;
         if (!us && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = r % 65536;
         if (!us && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
         v = r;
      end
      return v;
   endfunction

   function automatic logic exp_err(input logic [15:0] a, input logic [1:0] sz);
`ifdef LSU_MISALGN_CHK_EN
      return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
      return 1'b0 & a[0] & sz[0];
`endif
   endfunction

   // SRAM: read data appears just after the edge following a cs+read, garbage otherwise.
   initial begin
      dtcm_dout = '0;
      forever begin
         @(posedge clk);
         #1;
         dtcm_dout = rd_pend ? rd_data : $urandom;
      end
   end

   // Compare process: model of pending response, accepted commands and memory.
   always @(negedge clk) begin
      logic pend, rsp_m, hsk, em, acc;
      logic [3:0] idx;
      rsp_t e;
      if (rst) begin
         exp_q.delete();
         rd_pend = 1'b0;
      end else begin
         pend  = exp_q.size() != 0;
         rsp_m = pend && lsu_o_ready && agu_rsp_ready;
         chk("cmd_ready", agu_cmd_ready, !pend || rsp_m);
         chk("lsu_valid", lsu_o_valid, pend);
         chk("rsp_valid", agu_rsp_valid, pend);
         if (pend) begin
            chk("wdat", lsu_o_wbck_wdat, exp_q[0].wdat);
            chk("itag", lsu_o_wbck_itag, exp_q[0].itag);
            chk("read", lsu_o_wbck_read, exp_q[0].read);
            chk("err",  lsu_o_err,       exp_q[0].err);
         end
         hsk = agu_cmd_valid && (!pend || rsp_m);
         em  = exp_err(agu_cmd_addr, agu_cmd_size);
         acc = hsk && !em;
         chk("dtcm_cs", dtcm_cs, acc);
         chk("dtcm_we", dtcm_we, acc && !agu_cmd_read);
         if (acc) begin
            chk("dtcm_addr", dtcm_addr, agu_cmd_addr[15:2]);
            chk("dtcm_wem", dtcm_wem, agu_cmd_read ? 4'h0 : agu_cmd_wmask);
            if (!agu_cmd_read) chk("dtcm_din", dtcm_din, agu_cmd_wdata);
         end
         idx     = dtcm_addr[3:0];
         rd_pend = dtcm_cs && !dtcm_we;
         rd_data = sram_mem[idx];
         if (dtcm_cs && dtcm_we)
            for (int b = 0; b < 4; b++)
               if (dtcm_wem[b]) sram_mem[idx][8*b +: 8] = dtcm_din[8*b +: 8];
         if (rsp_m) void'(exp_q.pop_front());
         if (hsk) begin
            idx    = agu_cmd_addr[5:2];
            e.itag = agu_cmd_itag[0];
            e.read = agu_cmd_read;
            e.err  = em;
            e.wdat = (agu_cmd_read && !em) ?
                     exp_load(ref_mem[idx], agu_cmd_addr[1:0], agu_cmd_size, agu_cmd_usign) : 32'h0;
            exp_q.push_back(e);
            if (!agu_cmd_read && !em)
               for (int b = 0; b < 4; b++)
                  if (agu_cmd_wmask[b]) ref_mem[idx][8*b +: 8] = agu_cmd_wdata[8*b +: 8];
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic rd, input logic [31:0] wd,
                        input logic [3:0] wm, input logic tg, input logic us, input logic [1:0] sz);
      @(posedge clk);
      #1;
      agu_cmd_valid = 1'b1;
      agu_cmd_addr  = a;
      agu_cmd_read  = rd;
      agu_cmd_wdata = wd;
      agu_cmd_wmask = wm;
      agu_cmd_itag  = tg;
      agu_cmd_usign = us;
      agu_cmd_size  = sz;
      lsu_o_ready   = 1'b1;
      agu_rsp_ready = 1'b1;
   endtask

   task automatic idle(input logic lr);
      @(posedge clk);
      #1;
      agu_cmd_valid = 1'b0;
      lsu_o_ready   = lr;
      agu_rsp_ready = 1'b1;
   endtask

   task automatic load_chk(input string name, input logic [15:0] a, input logic tg,
                           input logic us, input logic [1:0] sz, input logic [31:0] exp);
      issue(a, 1'b1, 32'h0, 4'h0, tg, us, sz);
      @(negedge clk);
      chk({name, "_cs"}, dtcm_cs, 1);
      idle(1'b1);
      @(negedge clk);
      chk({name, "_vld"}, lsu_o_valid, 1);
      chk({name, "_wdat"}, lsu_o_wbck_wdat, exp);
      chk({name, "_itag"}, lsu_o_wbck_itag, tg);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         sram_mem[i] = $urandom;
         ref_mem[i]  = sram_mem[i];
      end
      sram_mem[4] = 32'h80FF_1234;
      ref_mem[4]  = 32'h80FF_1234;
      rst = 1'b1;
      agu_cmd_valid = 1'b0; agu_cmd_addr = '0; agu_cmd_read = 1'b0; agu_cmd_wdata = '0;
      agu_cmd_wmask = '0; agu_cmd_itag = '0; agu_cmd_usign = 1'b0; agu_cmd_size = '0;
      lsu_o_ready = 1'b1; agu_rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", agu_cmd_ready, 1);
      chk("rst_lsu_valid", lsu_o_valid, 0);
      chk("rst_rsp_valid", agu_rsp_valid, 0);
      chk("rst_cs", dtcm_cs, 0);
      chk("rst_we", dtcm_we, 0);
      chk("rst_addr", dtcm_addr, 0);
      chk("rst_wem", dtcm_wem, 0);
      chk("rst_din", dtcm_din, 0);
      chk("rst_wdat", lsu_o_wbck_wdat, 0);
      chk("rst_read", lsu_o_wbck_read, 0);
      chk("rst_err", lsu_o_err, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      load_chk("lb_s", 16'h0013, 1'b0, 1'b0, 2'd0, 32'hFFFF_FF80);
      load_chk("lb_u", 16'h0013, 1'b1, 1'b1, 2'd0, 32'h0000_0080);
      issue(16'h0010, 1'b0, 32'hBEEF_0000, 4'hF, 1'b0, 1'b0, 2'd2);
      idle(1'b1);
      load_chk("lh_u", 16'h0012, 1'b1, 1'b1, 2'd1, 32'h0000_BEEF);

      issue(16'h0010, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 2'd2);
      @(negedge clk);
      chk("sw_cs", dtcm_cs, 1);
      chk("sw_we", dtcm_we, 1);
      chk("sw_addr", dtcm_addr, 14'h004);
      chk("sw_wem", dtcm_wem, 4'hF);
      chk("sw_din", dtcm_din, 32'hDEAD_BEEF);
      idle(1'b1);
      @(negedge clk);
      chk("sw_vld", lsu_o_valid, 1);
      chk("sw_wdat", lsu_o_wbck_wdat, 0);
      chk("sw_read", lsu_o_wbck_read, 0);

      for (int i = 0; i < 4; i++) begin
         issue(16'(4 * i), 1'b1, 32'h0, 4'h0, 1'(i), 1'b0, 2'd2);
         @(negedge clk);
         chk("b2b_ready", agu_cmd_ready, 1);
         if (i > 0) chk("b2b_vld", lsu_o_valid, 1);
      end
      idle(1'b1);
      @(negedge clk);
      chk("b2b_last_vld", lsu_o_valid, 1);
      idle(1'b1);

      issue(16'h0020, 1'b0, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 2'd2);
      idle(1'b1);
      issue(16'h0020, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0, 2'd2);
      @(negedge clk);
      chk("stall_rdy0", agu_cmd_ready, 1);
      for (int k = 0; k < 3; k++) begin
         idle(1'b0);
         @(negedge clk);
         chk("stall_wdat", lsu_o_wbck_wdat, 32'h1234_5678);
         chk("stall_ready", agu_cmd_ready, 0);
      end
      idle(1'b1);
      @(negedge clk);
      chk("release_wdat", lsu_o_wbck_wdat, 32'h1234_5678);
      chk("release_ready", agu_cmd_ready, 1);
      idle(1'b1);

      issue(16'h0002, 1'b1, 32'h0, 4'h0, 1'b0, 1'b0, 2'd2);
      @(negedge clk);
`ifdef LSU_MISALGN_CHK_EN
      chk("mis_cs", dtcm_cs, 0);
      idle(1'b1);
      @(negedge clk);
      chk("mis_err", lsu_o_err, 1);
      chk("mis_wdat", lsu_o_wbck_wdat, 0);
`else
      chk("mis_cs", dtcm_cs, 1);
      chk("mis_addr", dtcm_addr, 0);
      idle(1'b1);
      @(negedge clk);
      chk("mis_err", lsu_o_err, 0);
`endif
      idle(1'b1);

      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            agu_cmd_valid = 1'b0;
         end else begin
            rst = 1'b0;
            agu_cmd_valid = $urandom_range(0, 9) < 7;
            agu_cmd_addr  = 16'($urandom_range(0, 63));
            agu_cmd_read  = 1'($urandom_range(0, 1));
            agu_cmd_wdata = $urandom;
            agu_cmd_wmask = 4'($urandom_range(0, 15));
            agu_cmd_itag  = 1'($urandom_range(0, 1));
            agu_cmd_usign = 1'($urandom_range(0, 1));
            agu_cmd_size  = 2'($urandom_range(0, 3));
            lsu_o_ready   = $urandom_range(0, 3) != 0;
            agu_rsp_ready = $urandom_range(0, 3) != 0;
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      agu_cmd_valid = 1'b0;
      lsu_o_ready = 1'b1;
      agu_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
